// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O responder: register map, STATUS bit
// positions and the 2-bit UART FSM state encoding used by both directions.
package j1_io_pkg;

  localparam logic [3:0] REG_UART_DATA = 4'd0;
  localparam logic [3:0] REG_STATUS    = 4'd1;
  localparam logic [3:0] REG_GPIO_OUT  = 4'd2;
  localparam logic [3:0] REG_GPIO_IN   = 4'd3;
  localparam logic [3:0] REG_TICKS     = 4'd4;

  localparam int ST_TX_IDLE   = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_TX_OVF    = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/j1_uart_tx.sv
// UART transmitter: TX FIFO, baud down-counter and serializer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   UART_IDLE  | line high; pops the FIFO head as soon as it is non-empty
//   UART_START | start bit (0) for BAUD_DIV clocks
//   UART_DATA  | 8 data bits LSB first, BAUD_DIV clocks each
//   UART_STOP  | stop bit (1); chains straight into the next START when
//              | the FIFO holds another byte, so queued bytes have no gap
module j1_uart_tx
  import j1_io_pkg::*;
#(
  parameter int BAUD_DIV = 217,
  parameter int TX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       idle,
  output logic       tx
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic fifo_empty;
  logic push_ok;
  logic pop;
  logic baud_tc;

  assign fifo_empty = (count == '0);
  assign full       = (count == (AW+1)'(TX_DEPTH));
  assign push_ok    = push && !full;
  assign baud_tc    = (baud_cnt == '0);
  // A byte leaves the FIFO either from IDLE or at the very end of STOP.
  assign pop        = !fifo_empty && ((state == UART_IDLE) || (state == UART_STOP && baud_tc));
  assign idle       = (state == UART_IDLE) && fifo_empty;

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // FIFO pointers and occupancy; a push into a full FIFO is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Serializer FSM with registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        UART_IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= CW'(BAUD_DIV - 1);
            tx       <= 1'b0;
            state    <= UART_START;
          end
        end
        UART_START: begin
          if (baud_tc) begin
            baud_cnt <= CW'(BAUD_DIV - 1);
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= UART_DATA;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        UART_DATA: begin
          if (baud_tc) begin
            baud_cnt <= CW'(BAUD_DIV - 1);
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= UART_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        UART_STOP: begin
          if (baud_tc) begin
            if (pop) begin
              shreg    <= mem[rd_ptr];
              baud_cnt <= CW'(BAUD_DIV - 1);
              tx       <= 1'b0;
              state    <= UART_START;
            end else begin
              state <= UART_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/j1_io_responder.sv
// J1 I/O bus target: address decode, combinational read mux, UART RX path,
// GPIO port and free-running tick counter. The TX side lives in j1_uart_tx.
//
//   rx state   | meaning
//   -----------+-----------------------------------------------------------
//   UART_IDLE  | waiting for a falling edge on the synchronized line
//   UART_START | half a bit in, re-check the line; high means a glitch
//   UART_DATA  | sample 8 bits, one every BAUD_DIV clocks, LSB first
//   UART_STOP  | sample the stop bit; 1 loads rx_data, 0 flags frame_err
module j1_io_responder
  import j1_io_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] IO_BASE  = 16'hF000,
  parameter int               BAUD_DIV = 217,
  parameter int               TX_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [WIDTH-1:0] io_addr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic [WIDTH-1:0] io_rdata,
  input  logic             uart_rx,
  output logic             uart_tx,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out
);

  localparam int CW = $clog2(BAUD_DIV);

  logic       hit;
  logic [3:0] offset;
  logic       wr_uart, wr_status, wr_gpio, wr_ticks, rd_uart;

  logic       tx_full, tx_idle;
  logic       rx_valid, rx_ovr, tx_ovf, frame_err;
  logic [7:0] rx_data;
  logic [15:0] ticks;

  logic       rx_s1, rx_s2, rx_prev;
  logic [7:0] gpio_s1, gpio_s2;

  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tc, rx_load, rx_ferr;

  assign hit       = (io_addr[WIDTH-1:4] == IO_BASE[WIDTH-1:4]);
  assign offset    = io_addr[3:0];
  assign wr_uart   = io_wr && hit && (offset == REG_UART_DATA);
  assign wr_status = io_wr && hit && (offset == REG_STATUS);
  assign wr_gpio   = io_wr && hit && (offset == REG_GPIO_OUT);
  assign wr_ticks  = io_wr && hit && (offset == REG_TICKS);
  assign rd_uart   = io_rd && hit && (offset == REG_UART_DATA);

  j1_uart_tx #(
    .BAUD_DIV (BAUD_DIV),
    .TX_DEPTH (TX_DEPTH)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_uart),
    .wdata (io_wdata[7:0]),
    .full  (tx_full),
    .idle  (tx_idle),
    .tx    (uart_tx)
  );

  // Two-flop synchronizers for the asynchronous inputs; rx_prev gives edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
    end
  end

  assign rx_tc   = (rx_cnt == '0);
  assign rx_load = (rx_state == UART_STOP) && rx_tc && rx_s2;
  assign rx_ferr = (rx_state == UART_STOP) && rx_tc && !rx_s2;

  // Receiver FSM: bit timing from a down-counter, mid-bit sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        UART_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= CW'(BAUD_DIV / 2 - 1);
            rx_state <= UART_START;
          end
        end
        UART_START: begin
          if (rx_tc) begin
            if (!rx_s2) begin
              rx_cnt   <= CW'(BAUD_DIV - 1);
              rx_bit   <= '0;
              rx_state <= UART_DATA;
            end else begin
              rx_state <= UART_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        UART_DATA: begin
          if (rx_tc) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= CW'(BAUD_DIV - 1);
            if (rx_bit == 3'd7) rx_state <= UART_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        UART_STOP: begin
          if (rx_tc) rx_state <= UART_IDLE;
          else       rx_cnt   <= rx_cnt - CW'(1);
        end
        default: rx_state <= UART_IDLE;
      endcase
    end
  end

  // RX holding register and status; a set event beats a same-cycle clear,
  // and a byte landing during a UART_DATA read keeps rx_valid without overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_uart) begin
        rx_valid <= 1'b0;
      end
      rx_ovr    <= (rx_load && rx_valid && !rd_uart) ||
                   (rx_ovr && !(wr_status && io_wdata[ST_RX_OVR]));
      tx_ovf    <= (wr_uart && tx_full) ||
                   (tx_ovf && !(wr_status && io_wdata[ST_TX_OVF]));
      frame_err <= rx_ferr ||
                   (frame_err && !(wr_status && io_wdata[ST_FRAME_ERR]));
    end
  end

  // GPIO output register and free-running tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      ticks    <= '0;
    end else begin
      if (wr_gpio) gpio_out <= io_wdata[7:0];
      if (wr_ticks) ticks <= io_wdata[15:0];
      else          ticks <= ticks + 16'd1;
    end
  end

  // Read mux; purely combinational so a simultaneous write shows the old value.
  always_comb begin
    io_rdata = '0;
    if (hit) begin
      case (offset)
        REG_UART_DATA: io_rdata = WIDTH'({8'h0, rx_data});
        REG_STATUS:    io_rdata = WIDTH'({10'h0, frame_err, rx_ovr, tx_ovf,
                                          rx_valid, tx_full, tx_idle});
        REG_GPIO_OUT:  io_rdata = WIDTH'({8'h0, gpio_out});
        REG_GPIO_IN:   io_rdata = WIDTH'({8'h0, gpio_s2});
        REG_TICKS:     io_rdata = WIDTH'(ticks);
        default:       io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_io_responder.sv
// Directed bench for j1_io_responder with BAUD_DIV=4, TX_DEPTH=8.
// uart_tx and STATUS[0] are logged once per clock so TX frames can be
// decoded and timed after the fact.
module tb_j1_io_responder;

  localparam int BD   = 4;
  localparam int LOGN = 8192;

  logic        clk, rst, io_rd, io_wr, uart_rx, uart_tx;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic [7:0]  gpio_in, gpio_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit tx_log   [0:LOGN-1];
  bit idle_log [0:LOGN-1];

  j1_io_responder #(
    .WIDTH    (16),
    .IO_BASE  (16'hF000),
    .BAUD_DIV (BD),
    .TX_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle sample log, taken mid low phase after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (cyc < LOGN) begin
      tx_log[cyc]   = uart_tx;
      idle_log[cyc] = io_rdata[0];
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr = 1'b1;
    @(posedge clk);
    #1 io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_rdata;
    @(posedge clk);
    #1 io_rd = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a;
    #1 d = io_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  // Expected line samples for one frame, index 0 = first start-bit clock.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < BD; k++)
        r[j*BD + k] = f[j];
    return r;
  endfunction

  task automatic find_frame(input string tag, input int from, input logic [7:0] b,
                            output int start);
    logic [39:0] got;
    logic        found;
    start = -1;
    for (int i = from; i < cyc && i < LOGN - 40; i++) begin
      if (!tx_log[i]) begin
        start = i;
        break;
      end
    end
    found = (start >= 0) && (start + 40 <= cyc);
    chk({tag, "_found"}, 64'(found), 64'd1);
    if (found) begin
      for (int i = 0; i < 40; i++) got[i] = tx_log[start + i];
      chk(tag, 64'(got), 64'(frame_bits(b)));
    end
  endtask

  logic [15:0] d, t1, t2;
  int c0, s, prev, zeros;

  initial begin
    rst = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
    uart_rx = 1'b1; gpio_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state and tick counter
    rd(16'hF001, d);
    chk("rst_status", d, 16'h0001);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_gpio_out", gpio_out, 8'h00);
    peek(16'hF004, t1);
    repeat (3) @(negedge clk);
    #1 t2 = io_rdata;
    chk("ticks_delta", 16'(t2 - t1), 16'd3);

    // 2: single TX frame, tx_idle returns after the stop bit
    c0 = cyc;
    wr(16'hF000, 16'h00A5);
    io_addr = 16'hF001;
    repeat (50) @(negedge clk);
    find_frame("tx_a5", c0, 8'hA5, s);
    if (s >= 0) begin
      chk("idle_during_stop", idle_log[s + 39], 1'b0);
      chk("idle_after_stop", idle_log[s + 40], 1'b1);
    end

    // 3: FIFO overflow. The first byte is popped into the serializer one
    // edge after it lands, so nine writes fill the eight FIFO slots and
    // the tenth is the one dropped.
    c0 = cyc;
    for (int i = 0; i < 9; i++) wr(16'hF000, 16'h0010 + 16'(i));
    peek(16'hF001, d);
    chk("status_full", d, 16'h0002);
    wr(16'hF000, 16'h0019);
    peek(16'hF001, d);
    chk("status_ovf", d, 16'h000A);
    repeat (9*40 + 20) @(negedge clk);
    prev = -1;
    for (int k = 0; k < 9; k++) begin
      find_frame($sformatf("burst_%0d", k), (k == 0) ? c0 : prev + 40, 8'h10 + 8'(k), s);
      if (k > 0) chk($sformatf("burst_gap_%0d", k), 64'(s - prev), 64'd40);
      prev = s;
    end
    zeros = 0;
    if (prev >= 0)
      for (int i = prev + 40; i < cyc && i < LOGN; i++) if (!tx_log[i]) zeros++;
    chk("no_dropped_frame", 64'(zeros), 64'd0);
    peek(16'hF001, d);
    chk("status_after_burst", d, 16'h0009);
    wr(16'hF001, 16'h0008);
    peek(16'hF001, d);
    chk("ovf_cleared", d, 16'h0001);

    // 4: RX receive, read clear, overrun
    send_rx(8'h3C, 1'b1);
    peek(16'hF001, d);
    chk("rx_valid_set", d, 16'h0005);
    rd(16'hF000, d);
    chk("rx_data_3c", d, 16'h003C);
    peek(16'hF001, d);
    chk("rx_valid_clr", d, 16'h0001);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    peek(16'hF001, d);
    chk("rx_ovr_set", d, 16'h0015);
    rd(16'hF000, d);
    chk("rx_data_2nd", d, 16'h0022);
    wr(16'hF001, 16'h0010);
    peek(16'hF001, d);
    chk("rx_ovr_clr", d, 16'h0001);

    // 5: framing error and glitch rejection
    send_rx(8'h55, 1'b0);
    peek(16'hF001, d);
    chk("frame_err", d, 16'h0021);
    wr(16'hF001, 16'h0020);
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    peek(16'hF001, d);
    chk("glitch_ignored", d, 16'h0001);
    send_rx(8'h81, 1'b1);
    rd(16'hF000, d);
    chk("rx_after_glitch", d, 16'h0081);

    // 6: GPIO, decode, rd+wr overlap, TICKS wrap, reset mid-frame
    wr(16'hF002, 16'h005A);
    chk("gpio_out_5a", gpio_out, 8'h5A);
    rd(16'hF002, d);
    chk("gpio_out_rd", d, 16'h005A);
    gpio_in = 8'hC3;
    repeat (3) @(negedge clk);
    rd(16'hF003, d);
    chk("gpio_in_rd", d, 16'h00C3);
    rd(16'hF007, d);
    chk("unmapped_rd", d, 16'h0000);
    wr(16'hE002, 16'h00FF);
    chk("outside_wr", gpio_out, 8'h5A);
    rd(16'hE002, d);
    chk("outside_rd", d, 16'h0000);
    wr(16'hF007, 16'hFFFF);
    chk("unmapped_wr", gpio_out, 8'h5A);
    @(negedge clk);
    io_addr = 16'hF002; io_wdata = 16'h0033; io_rd = 1'b1; io_wr = 1'b1;
    #1 d = io_rdata;
    chk("rw_pre_value", d, 16'h005A);
    @(posedge clk);
    #1 begin io_rd = 1'b0; io_wr = 1'b0; end
    chk("rw_write_took", gpio_out, 8'h33);
    wr(16'hF004, 16'hFFFF);
    peek(16'hF004, d);
    chk("ticks_load", d, 16'hFFFF);
    @(negedge clk);
    #1 d = io_rdata;
    chk("ticks_wrap", d, 16'h0000);

    wr(16'hF000, 16'h0000);
    repeat (12) @(negedge clk);
    chk("tx_low_mid_frame", uart_tx, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("tx_high_on_rst", uart_tx, 1'b1);
    @(negedge clk) rst = 1'b0;
    peek(16'hF001, d);
    chk("status_after_rst", d, 16'h0001);
    chk("gpio_after_rst", gpio_out, 8'h00);
    c0 = cyc;
    repeat (50) @(negedge clk);
    zeros = 0;
    for (int i = c0; i < cyc && i < LOGN; i++) if (!tx_log[i]) zeros++;
    chk("tx_quiet_after_rst", 64'(zeros), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
